// File: rtl/tiny85_port_sched_pkg.sv
// tiny85_pkg -- shared definitions for the tiny85 port scheduler.
//   PORT_W          : width of the PB5..PB0 port
//   state_e         : scheduler FSM states
//   TIMEOUT_DEFAULT : default REQ-phase timeout in cycles
package tiny85_pkg;

  localparam int unsigned PORT_W          = 6;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_REQ    = 3'd3,
    ST_DRIVE  = 3'd4
  } state_e;

endpackage

// File: rtl/tiny85_port_sched_pin_sync.sv
// tiny85_pin_sync -- per-bit flop synchronizer for asynchronous pin levels.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset, clears every stage
//   pin_i   : raw asynchronous pin levels
//   pin_o   : synchronized pin levels (STAGES cycles of latency)
module tiny85_pin_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o
);

  logic [WIDTH-1:0] stg_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= pin_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign pin_o = stg_q[STAGES-1];

endmodule

// File: rtl/tiny85_port_sched.sv
// tiny85_port_sched -- schedules PINB/PORTB exchanges with a C model bridge
// and drives the resulting port pins.
// Optional feature macro: TINY85_PORT_SCHED_DBG_EN (debug override path).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   vcc, gnd             : supply pins, powered = vcc & ~gnd
//   pin_in               : raw asynchronous PB5..PB0 levels
//   tick                 : single-cycle exchange start strobe
//   mdl_req, mdl_pinb    : exchange request and PINB snapshot to the model
//   mdl_ack              : model response valid
//   mdl_portb, mdl_ddrb  : model PORTB/DDRB, valid with mdl_ack
//   dbg_req, dbg_portb   : debug override request and data
//   dbg_gnt              : debug grant pulse
//   port_out, port_oe    : driven pin values and output enables
//   busy                 : exchange in progress
//   timeout_err          : sticky, model failed to ack within TIMEOUT cycles
//   tick_ovr             : sticky, tick arrived outside IDLE and was dropped
module tiny85_port_sched
  import tiny85_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vcc,
  input  logic              gnd,
  input  logic [PORT_W-1:0] pin_in,
  input  logic              tick,
  output logic              mdl_req,
  output logic [PORT_W-1:0] mdl_pinb,
  input  logic              mdl_ack,
  input  logic [PORT_W-1:0] mdl_portb,
  input  logic [PORT_W-1:0] mdl_ddrb,
  input  logic              dbg_req,
  input  logic [PORT_W-1:0] dbg_portb,
  output logic              dbg_gnt,
  output logic [PORT_W-1:0] port_out,
  output logic [PORT_W-1:0] port_oe,
  output logic              busy,
  output logic              timeout_err,
  output logic              tick_ovr
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [PORT_W-1:0] pin_sync;
  logic [PORT_W-1:0] mdl_pinb_q;
  logic [PORT_W-1:0] portb_q, ddrb_q;
  logic [PORT_W-1:0] port_out_q, port_oe_q;
  logic              mdl_req_q, dbg_gnt_q, busy_q;
  logic              timeout_err_q, tick_ovr_q;
  logic [7:0]        tmo_cnt_q;
  logic              powered;

  assign powered = vcc & ~gnd;

`ifndef TINY85_PORT_SCHED_DBG_EN
  logic dbg_unused;
  assign dbg_unused = ^{dbg_req, dbg_portb};
`endif

  tiny85_pin_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (PORT_W)
  ) u_pin_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pin_i  (pin_in),
    .pin_o  (pin_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      mdl_pinb_q    <= '0;
      portb_q       <= '0;
      ddrb_q        <= '0;
      port_out_q    <= '0;
      port_oe_q     <= '0;
      mdl_req_q     <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tick_ovr_q    <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      // Grant is a one-cycle pulse unless re-issued below.
      dbg_gnt_q <= 1'b0;

      if (tick && (state_q != ST_IDLE)) begin
        tick_ovr_q <= 1'b1;
      end

      if (!powered) begin
        // Power loss overrides every state; sticky flags survive.
        state_q    <= ST_OFF;
        port_out_q <= '0;
        port_oe_q  <= '0;
        mdl_req_q  <= 1'b0;
        busy_q     <= 1'b0;
        tmo_cnt_q  <= '0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            state_q <= ST_IDLE;
          end

          ST_IDLE: begin
            if (tick) begin
              state_q <= ST_SAMPLE;
              busy_q  <= 1'b1;
            end
`ifdef TINY85_PORT_SCHED_DBG_EN
            // Tick has priority; a held dbg_req is granted on a later IDLE
            // cycle. Grant and the override land on the same edge, and a
            // held request re-arms only after the pulse has dropped.
            else if (dbg_req && !dbg_gnt_q) begin
              dbg_gnt_q  <= 1'b1;
              port_out_q <= dbg_portb & port_oe_q;
            end
`endif
          end

          ST_SAMPLE: begin
            mdl_pinb_q <= pin_sync;
            mdl_req_q  <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= ST_REQ;
          end

          ST_REQ: begin
            if (mdl_ack) begin
              portb_q   <= mdl_portb;
              ddrb_q    <= mdl_ddrb;
              mdl_req_q <= 1'b0;
              state_q   <= ST_DRIVE;
            end else if (tmo_cnt_q == TMO_LAST) begin
              // Abandon the exchange; pins keep their previous drive.
              timeout_err_q <= 1'b1;
              mdl_req_q     <= 1'b0;
              busy_q        <= 1'b0;
              state_q       <= ST_IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
          end

          ST_DRIVE: begin
            port_out_q <= portb_q & ddrb_q;
            port_oe_q  <= ddrb_q;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end

          default: begin
            state_q   <= ST_OFF;
            mdl_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mdl_req     = mdl_req_q;
  assign mdl_pinb    = mdl_pinb_q;
  assign dbg_gnt     = dbg_gnt_q;
  assign port_out    = port_out_q;
  assign port_oe     = port_oe_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign tick_ovr    = tick_ovr_q;

endmodule

// File: doc/tiny85_port_sched.md
TINY85_PORT_SCHED -- requirements
Module: tiny85_port_sched

Interface
REQ-001 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..3.
REQ-002 Parameter TIMEOUT, default 15: maximum REQ cycles without mdl_ack, legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 vcc, gnd  in  1 each  supply pins; powered = vcc & ~gnd.
REQ-006 pin_in  in  6  raw PB5..PB0 pin levels, asynchronous.
REQ-007 tick  in  1  single-cycle exchange start strobe.
REQ-008 mdl_req  out  1  exchange request to the C model bridge.
REQ-009 mdl_pinb  out  6  PINB snapshot presented with mdl_req.
REQ-010 mdl_ack  in  1  model response valid.
REQ-011 mdl_portb, mdl_ddrb  in  6 each  model PORTB/DDRB values, valid with mdl_ack.
REQ-012 dbg_req  in  1, dbg_portb  in  6, dbg_gnt  out  1  debug override request, data and grant.
REQ-013 port_out, port_oe  out  6 each  driven pin values and output enables.
REQ-014 busy  out  1, timeout_err  out  1, tick_ovr  out  1  status flags.

Function
REQ-015 FSM states: OFF, IDLE, SAMPLE, REQ, DRIVE; state is registered.
REQ-016 IDLE with tick=1 -> SAMPLE on the next cycle; busy=1 in every state except IDLE and OFF.
REQ-017 SAMPLE: capture the synchronized pins into mdl_pinb (one cycle) -> REQ.
REQ-018 REQ: mdl_req=1 and mdl_pinb held stable until mdl_ack=1 is sampled; then latch mdl_portb/mdl_ddrb -> DRIVE.
REQ-019 DRIVE: port_out <= latched portb & latched ddrb, port_oe <= latched ddrb, both registered -> IDLE; tick-to-pin latency is exactly 4 cycles when mdl_ack is returned in the first REQ cycle.
REQ-020 REQ timeout: after TIMEOUT cycles without ack, set timeout_err (sticky), leave port_out/port_oe unchanged, drop mdl_req, return to IDLE.
REQ-021 An mdl_ack outside REQ is ignored.
REQ-022 A tick in any state other than IDLE is dropped and sets tick_ovr (sticky).
REQ-023 Arbitration, IDLE only: if tick and dbg_req are both 1, tick wins; dbg_req stays pending.
REQ-024 Debug grant: in IDLE with tick=0 and dbg_req=1, dbg_gnt pulses for 1 cycle and port_out <= dbg_portb & port_oe on the next edge.
REQ-025 Power loss: powered=0 in any state -> OFF on the next edge; port_out=0, port_oe=0, mdl_req=0, dbg_gnt=0 while in OFF.
REQ-026 Power return: OFF with powered=1 -> IDLE; sticky flags are preserved.

Reset
REQ-027 rst_n=0 at a clock edge -> state OFF, port_out=0, port_oe=0, mdl_pinb=0, mdl_req=0, dbg_gnt=0, busy=0, timeout_err=0, tick_ovr=0, synchronizer stages=0, timeout counter=0.
REQ-028 Reset during REQ aborts the exchange; a later mdl_ack for the aborted exchange is ignored.

Configuration
REQ-029 Macro TINY85_PORT_SCHED_DBG_EN defined: debug override logic per REQ-023/REQ-024 is present.
REQ-030 Macro TINY85_PORT_SCHED_DBG_EN undefined: dbg_req and dbg_portb are ignored and dbg_gnt is tied to 0; all other behaviour is identical.

Structure
REQ-031 Package tiny85_pkg holds PORT_W=6, the FSM state enum, and the default TIMEOUT constant.
REQ-032 Sub-module tiny85_pin_sync: SYNC_STAGES-deep per-bit flop synchronizer for pin_in, with synchronous reset to 0.

Verification
REQ-033 Reset, powered, tick, pin_in=6'b101100, ack in the first REQ cycle with portb=6'h03, ddrb=6'h03 -> mdl_pinb=6'h2C, port_out=6'h03, port_oe=6'h03, 4 cycles after tick.
REQ-034 No ack for 15 REQ cycles -> timeout_err=1, port_out unchanged, state IDLE on cycle 16.
REQ-035 tick and dbg_req=1 in the same IDLE cycle -> model exchange first, then dbg_gnt pulses in the first IDLE cycle after DRIVE.
REQ-036 vcc drops to 0 mid-REQ -> next cycle state OFF, port_out=0, port_oe=0, mdl_req=0; vcc returns -> IDLE.
REQ-037 tick asserted while busy=1 -> tick_ovr=1 and no extra exchange occurs.
REQ-038 Build without TINY85_PORT_SCHED_DBG_EN, dbg_req=1 held for 20 cycles -> dbg_gnt stays 0 and port_out is unchanged.
